// File: rtl/control_unit_pipe.sv
// RV32I instruction decoder feeding a small in-order FIFO of decoded control entries.
// Illegal instructions are counted (saturating) and flagged in the entry with all enables cleared.
module control_unit_pipe #(
    parameter int DEPTH        = 2,
    parameter int CNT_W        = 16,
    parameter int SUPPORT_JUMP = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_reg_w_enable,
    output logic [2:0]               out_imm_sel,
    output logic [3:0]               out_alu_control,
    output logic                     out_alu_mux_in,
    output logic                     out_alu_src_pc,
    output logic                     out_alu_mux_out,
    output logic                     out_ram_w_enable,
    output logic                     out_br_enable,
    output logic                     out_br_mux_inv,
    output logic                     out_jump,
    output logic                     out_jalr,
    output logic                     out_wb_pc4,
    output logic [2:0]               out_databus,
    output logic                     out_illegal,
    output logic [CNT_W-1:0]         illegal_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      L_FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] C_MAX  = '1;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_SLL = 4'b0010,
                           ALU_SLT = 4'b0100, ALU_SLTU = 4'b0110, ALU_EQ = 4'b0111,
                           ALU_XOR = 4'b1000, ALU_SRL = 4'b1010, ALU_SRA = 4'b1011,
                           ALU_OR = 4'b1100, ALU_AND = 4'b1110, ALU_PASSB = 4'b1111;
    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                           IMM_U = 3'b011, IMM_J = 3'b100;

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_f7_zero, w_f7_alt;
    logic [3:0]  w_alu_f3;
    logic        w_reg_w, w_mux_in, w_src_pc, w_mux_out, w_ram_w, w_br, w_inv;
    logic        w_jump, w_jalr, w_wb_pc4, w_ill;
    logic [2:0]  w_imm, w_db;
    logic [3:0]  w_alu;
    logic [20:0] w_entry, w_head;
    logic        w_push, w_pop, w_unused_bits;

    assign w_op          = in_instr[6:0];
    assign w_f3          = in_instr[14:12];
    assign w_f7          = in_instr[31:25];
    assign w_f7_zero     = (w_f7 == 7'b0000000);
    assign w_f7_alt      = (w_f7 == 7'b0100000);
    assign w_unused_bits = ^{in_instr[24:15], in_instr[11:7]};

    always_comb begin
        case (w_f3)
            3'b000:  w_alu_f3 = ALU_ADD;
            3'b001:  w_alu_f3 = ALU_SLL;
            3'b010:  w_alu_f3 = ALU_SLT;
            3'b011:  w_alu_f3 = ALU_SLTU;
            3'b100:  w_alu_f3 = ALU_XOR;
            3'b101:  w_alu_f3 = ALU_SRL;
            3'b110:  w_alu_f3 = ALU_OR;
            default: w_alu_f3 = ALU_AND;
        endcase
    end

    always_comb begin
        w_reg_w = 1'b0; w_mux_in = 1'b0; w_src_pc = 1'b0; w_mux_out = 1'b0;
        w_ram_w = 1'b0; w_br = 1'b0; w_inv = 1'b0; w_jump = 1'b0;
        w_jalr = 1'b0; w_wb_pc4 = 1'b0; w_ill = 1'b0;
        w_imm = IMM_I; w_db = 3'b000; w_alu = ALU_ADD;
        case (w_op)
            7'b0110011: begin
                w_reg_w = 1'b1; w_mux_in = 1'b1; w_mux_out = 1'b1;
                if (w_f7_zero)                      w_alu = w_alu_f3;
                else if (w_f7_alt && w_f3 == 3'b000) w_alu = ALU_SUB;
                else if (w_f7_alt && w_f3 == 3'b101) w_alu = ALU_SRA;
                else                                w_ill = 1'b1;
            end
            7'b0010011: begin
                w_reg_w = 1'b1; w_mux_out = 1'b1; w_alu = w_alu_f3;
                if (w_f3 == 3'b001 && !w_f7_zero) w_ill = 1'b1;
                if (w_f3 == 3'b101) begin
                    if (w_f7_alt)        w_alu = ALU_SRA;
                    else if (!w_f7_zero) w_ill = 1'b1;
                end
            end
            7'b0000011: begin
                w_reg_w = 1'b1;
                case (w_f3)
                    3'b000:  w_db = 3'b010;
                    3'b001:  w_db = 3'b001;
                    3'b010:  w_db = 3'b000;
                    3'b100:  w_db = 3'b100;
                    3'b101:  w_db = 3'b011;
                    default: w_ill = 1'b1;
                endcase
            end
            7'b0100011: begin
                w_ram_w = 1'b1; w_imm = IMM_S;
                case (w_f3)
                    3'b000:  w_db = 3'b010;
                    3'b001:  w_db = 3'b001;
                    3'b010:  w_db = 3'b000;
                    default: w_ill = 1'b1;
                endcase
            end
            7'b1100011: begin
                w_br = 1'b1; w_mux_in = 1'b1; w_imm = IMM_B; w_inv = w_f3[0];
                case (w_f3[2:1])
                    2'b00:   w_alu = ALU_EQ;
                    2'b10:   w_alu = ALU_SLT;
                    2'b11:   w_alu = ALU_SLTU;
                    default: w_ill = 1'b1;
                endcase
            end
            7'b1101111: begin
                w_reg_w = 1'b1; w_jump = 1'b1; w_wb_pc4 = 1'b1; w_imm = IMM_J;
                w_ill = (SUPPORT_JUMP == 0);
            end
            7'b1100111: begin
                w_reg_w = 1'b1; w_jump = 1'b1; w_jalr = 1'b1; w_wb_pc4 = 1'b1;
                w_ill = (SUPPORT_JUMP == 0) || (w_f3 != 3'b000);
            end
            7'b0110111: begin
                w_reg_w = 1'b1; w_alu = ALU_PASSB; w_mux_out = 1'b1; w_imm = IMM_U;
                w_ill = (SUPPORT_JUMP == 0);
            end
            7'b0010111: begin
                w_reg_w = 1'b1; w_src_pc = 1'b1; w_mux_out = 1'b1; w_imm = IMM_U;
                w_ill = (SUPPORT_JUMP == 0);
            end
            default: w_ill = 1'b1;
        endcase
    end

    // An illegal entry carries nothing but its flag.
    assign w_entry = w_ill ? 21'd1 :
        {w_reg_w, w_imm, w_alu, w_mux_in, w_src_pc, w_mux_out, w_ram_w, w_br,
         w_inv, w_jump, w_jalr, w_wb_pc4, w_db, 1'b0};

    logic [20:0]         r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [AW:0]         r_level;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_live;

    assign in_ready  = r_live && (r_level != L_FULL);
    assign out_valid = (r_level != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_cnt    <= '0;
            r_live   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= w_entry;
                    r_wr_ptr        <= r_wr_ptr + AW'(1);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
                else if (w_pop && !w_push) r_level <= r_level - (AW+1)'(1);
            end
            if (w_push && w_ill && r_cnt != C_MAX) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_head = out_valid ? r_mem[r_rd_ptr] : 21'd0;
    assign {out_reg_w_enable, out_imm_sel, out_alu_control, out_alu_mux_in, out_alu_src_pc,
            out_alu_mux_out, out_ram_w_enable, out_br_enable, out_br_mux_inv, out_jump,
            out_jalr, out_wb_pc4, out_databus, out_illegal} = w_head;
    assign illegal_count = r_cnt;
    assign fifo_level    = r_level;
endmodule

// File: doc/control_unit_pipe.md
CONTROL_UNIT_PIPE -- requirements
Module: control_unit_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: rst_n is sampled only on the rising edge of clk.
REQ-002 Parameter DEPTH, default 2: decoded-entry FIFO depth; SHALL be a power of two and at least 2.
REQ-003 Parameter CNT_W, default 16: width of the illegal-instruction counter.
REQ-004 Parameter SUPPORT_JUMP, default 1: when 1, JAL, JALR, LUI and AUIPC decode; when 0, they are illegal.
REQ-005 Ports SHALL be exactly these:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  discard all buffered entries
- in_valid  in  1  in_instr is valid
- in_ready  out  1  block can accept an instruction
- in_instr  in  32  raw RV32I instruction
- out_valid  out  1  head entry is valid
- out_ready  in  1  consumer takes the head entry
- out_reg_w_enable  out  1  register-file write
- out_imm_sel  out  3  immediate type: I=000, S=001, B=010, U=011, J=100
- out_alu_control  out  4  ALU operation
- out_alu_mux_in  out  1  ALU operand B: 1=rs2, 0=immediate
- out_alu_src_pc  out  1  ALU operand A: 1=PC, 0=rs1
- out_alu_mux_out  out  1  writeback source: 1=ALU, 0=memory
- out_ram_w_enable  out  1  memory write
- out_br_enable  out  1  conditional branch
- out_br_mux_inv  out  1  invert branch condition
- out_jump  out  1  unconditional jump (JAL or JALR)
- out_jalr  out  1  jump target is register-based
- out_wb_pc4  out  1  writeback value is PC+4
- out_databus  out  3  load/store size: w=000, h=001, b=010, hu=011, bu=100
- out_illegal  out  1  entry was an illegal instruction
- illegal_count  out  CNT_W  count of accepted illegal instructions
- fifo_level  out  $clog2(DEPTH)+1  current entry count

Function
REQ-006 Decode SHALL be combinational on in_instr; the decoded entry is written into the FIFO when in_valid and in_ready are both 1.
REQ-007 Every decoded field not explicitly set for an opcode SHALL be 0; no field may hold a previous value.
REQ-008 ALU codes SHALL be: add 0000, sub 0001, sll 0010, slt 0100, sltu 0110, eq 0111, xor 1000, srl 1010, sra 1011, or 1100, and 1110, passB 1111.
REQ-009 Decode rules by opcode:
- R 0110011: reg_w=1, mux_in=1, mux_out=1. funct3 000 with funct7 0100000 is sub; 101 with funct7 0100000 is sra.
- I-ALU 0010011: as R but mux_in=0, imm_sel=I.
- Load 0000011: reg_w=1, add, mux_out=0, imm_sel=I, databus per funct3.
- Store 0100011: ram_w=1, add, imm_sel=S, databus per funct3.
- Branch 1100011: br_enable=1, mux_in=1, imm_sel=B. beq/bne use eq, blt/bge use slt, bltu/bgeu use sltu. br_mux_inv=1 for bne, bge, bgeu.
- JAL 1101111: reg_w=1, jump=1, wb_pc4=1, imm_sel=J.
- JALR 1100111 with funct3 000: reg_w=1, jump=1, jalr=1, wb_pc4=1, add, imm_sel=I.
- LUI 0110111: reg_w=1, passB, mux_out=1, imm_sel=U.
- AUIPC 0010111: reg_w=1, add, alu_src_pc=1, mux_out=1, imm_sel=U.
REQ-010 The following SHALL be illegal:
- any other opcode;
- an unlisted funct3 or funct7 combination, including funct7 other than 0000000/0100000 on R-type and on slli/srli/srai;
- the SUPPORT_JUMP=0 cases in REQ-004.
An illegal entry SHALL have all enables 0 (reg_w, ram_w, br_enable, jump) and out_illegal=1.
REQ-011 in_ready SHALL equal (fifo_level != DEPTH) and SHALL be 0 during reset; a full FIFO has no pass-through.
REQ-012 out_valid SHALL equal (fifo_level != 0). The out_* fields SHALL show the head entry, and SHALL be all 0 when the FIFO is empty.
REQ-013 Latency: an instruction accepted at edge N appears at the output after edge N when the FIFO was empty. Otherwise the FIFO is strictly in order.
REQ-014 A push and a pop in the same cycle SHALL leave fifo_level unchanged. Read and write pointers wrap modulo DEPTH.
REQ-015 When flush=1, the next edge SHALL set fifo_level to 0 and both pointers to 0. Flush overrides any same-cycle push or pop, and the flushed-cycle push is not counted.
REQ-016 illegal_count SHALL increment on each accepted illegal instruction and saturate at 2^CNT_W-1. Flush SHALL NOT affect it.

Reset
REQ-017 While rst_n=0 at an edge, the block SHALL set fifo_level=0, pointers=0, illegal_count=0, out_valid=0 and all out_* fields 0. This applies mid-operation and overrides flush and push.
REQ-018 in_ready SHALL return to 1 on the first edge with rst_n=1.

Verification
REQ-019 Accept in_instr 0x40208033 (sub) into an empty FIFO -> next cycle out_valid=1, alu_control=0001, reg_w=1, mux_in=1, mux_out=1.
REQ-020 DEPTH=2, out_ready=0, push 3 valid instructions -> fifo_level=2 and in_ready=0 after the second push. The third is not accepted; pops return the first two in order.
REQ-021 Push 0xFFFFFFFF with CNT_W=2, five times -> out_illegal=1 with all enables 0 each time; illegal_count=3 (saturated).
REQ-022 Full FIFO, assert flush with in_valid=1 -> next cycle fifo_level=0, out_valid=0, illegal_count unchanged.
REQ-023 SUPPORT_JUMP=0, push 0x0000006F (JAL) -> out_illegal=1. SUPPORT_JUMP=1, same push -> jump=1, wb_pc4=1, imm_sel=100.
REQ-024 Pull rst_n low with 2 entries buffered and illegal_count=5 -> after the edge all outputs are 0 and in_ready=0; one cycle after release, in_ready=1.
